// File: rtl/merge_buffered_arb.sv
// N-input elastic merge: arbitrates among valid producers and buffers each
// accepted token, tagged with its source channel, in a DEPTH-slot FIFO.
// Only the granted input ever sees ready, so held-off producers keep their data.
module merge_buffered_arb #(
  parameter int unsigned INPUTS   = 2,
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ARB_MODE = 0,
  localparam int unsigned IDXW    = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INPUTS*BITWIDTH-1:0] ins,
  input  logic [INPUTS-1:0]          ins_valid,
  output logic [INPUTS-1:0]          ins_ready,
  output logic [BITWIDTH-1:0]        outs,
  output logic [IDXW-1:0]            outs_index,
  output logic                       outs_valid,
  input  logic                       outs_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BITWIDTH-1:0] data_q [DEPTH];
  logic [IDXW-1:0]     idx_q  [DEPTH];

  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IDXW-1:0] last_q, last_d;

  logic            gnt_vld;
  logic [IDXW-1:0] gnt_idx;
  logic            space;
  logic            push;
  logic            pop;

  // Arbiter: loops run from lowest to highest priority so the last hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (ARB_MODE == 0) begin
      for (int i = INPUTS - 1; i >= 0; i--) begin
        if (ins_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDXW'(i);
        end
      end
    end else begin
      // Round-robin: scan last+1 .. last+INPUTS, nearest offset wins.
      for (int k = INPUTS; k >= 1; k--) begin
        if (ins_valid[(int'(last_q) + k) % INPUTS]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDXW'((int'(last_q) + k) % INPUTS);
        end
      end
    end
  end

  // Handshake: a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    pop       = outs_valid & outs_ready;
    space     = (count_q < CW'(DEPTH)) | pop;
    push      = gnt_vld & space;
    ins_ready = '0;
    if (gnt_vld && space) begin
      ins_ready[gnt_idx] = 1'b1;
    end
  end

  // Head slot drives the outputs directly from registered storage.
  always_comb begin
    outs_valid = (count_q != '0);
    outs       = data_q[rd_q];
    outs_index = idx_q[rd_q];
  end

  // Next-state for pointers, occupancy and round-robin history.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    last_d  = last_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      wr_d   = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      last_d = gnt_idx;
    end
    if (pop) begin
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    end
  end

  // Control state; reset leaves input 0 as the first round-robin candidate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      last_q  <= IDXW'(INPUTS - 1);
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  // FIFO storage; cleared on reset so the idle outputs read zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
        idx_q[s]  <= '0;
      end
    end else if (push) begin
      data_q[wr_q] <= ins[gnt_idx*BITWIDTH +: BITWIDTH];
      idx_q[wr_q]  <= gnt_idx;
    end
  end

endmodule
